// File: rtl/tecmo_pkg.sv
// Shared definitions for the ROM download path: bus widths, writer FSM states
// and the byte-address to SDRAM word-address mapping.
package tecmo_pkg;

  localparam int SDRAM_ADDR_WIDTH = 23;
  localparam int SDRAM_DATA_WIDTH = 32;
  localparam int IOCTL_ADDR_WIDTH = 20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_REQ   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } dl_state_e;

  // Four download bytes share one SDRAM word; the sum wraps modulo 2^23.
  function automatic logic [SDRAM_ADDR_WIDTH-1:0] word_address(
    input logic [SDRAM_ADDR_WIDTH-1:0] base,
    input logic [IOCTL_ADDR_WIDTH-3:0] word_index
  );
    return base + SDRAM_ADDR_WIDTH'(word_index);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs download bytes little-endian into one 32-bit word, tracks which lanes
// were written, and parks one byte that belongs to the next word.
module byte_packer
  import tecmo_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        wr,
  input  logic                        defer,
  input  logic                        commit,
  input  logic [1:0]                  lane,
  input  logic [7:0]                  data,
  input  logic [SDRAM_ADDR_WIDTH-1:0] addr,
  output logic [SDRAM_DATA_WIDTH-1:0] word,
  output logic [SDRAM_ADDR_WIDTH-1:0] word_addr,
  output logic                        any_valid,
  output logic                        pend_valid,
  output logic                        pend_full
);

  logic [3:0]                  lane_valid;
  logic [1:0]                  pend_lane;
  logic [7:0]                  pend_data;
  logic [SDRAM_ADDR_WIDTH-1:0] pend_addr;

  // A committed word leaves an all-zero buffer, so unwritten lanes read as 00;
  // the parked byte (if any) then becomes the first lane of the new word.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word       <= '0;
      word_addr  <= '0;
      lane_valid <= '0;
      pend_valid <= 1'b0;
      pend_lane  <= '0;
      pend_data  <= '0;
      pend_addr  <= '0;
    end else if (commit) begin
      word       <= '0;
      lane_valid <= '0;
      if (pend_valid) begin
        word[{pend_lane, 3'b000} +: 8] <= pend_data;
        lane_valid[pend_lane]          <= 1'b1;
        word_addr                      <= pend_addr;
        pend_valid                     <= 1'b0;
      end
    end else if (wr) begin
      if (defer) begin
        pend_valid <= 1'b1;
        pend_lane  <= lane;
        pend_data  <= data;
        pend_addr  <= addr;
      end else begin
        word[{lane, 3'b000} +: 8] <= data;
        lane_valid[lane]          <= 1'b1;
        word_addr                 <= addr;
      end
    end
  end

  assign any_valid = |lane_valid;
  assign pend_full = pend_valid && (pend_lane == 2'd3);

endmodule

// File: rtl/rom_download_writer.sv
// Turns the byte-wide ioctl ROM download into 32-bit SDRAM word writes.
// Define DOWNLOAD_CHECKSUM_EN to add a 16-bit sum of all accepted bytes.
module rom_download_writer
  import tecmo_pkg::*;
#(
  parameter logic [SDRAM_ADDR_WIDTH-1:0] BASE_ADDR = 23'h000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ioctl_download,
  input  logic                        ioctl_wr,
  input  logic [IOCTL_ADDR_WIDTH-1:0] ioctl_addr,
  input  logic [7:0]                  ioctl_data,
  output logic                        ioctl_wait,
  output logic [SDRAM_ADDR_WIDTH-1:0] sdram_addr,
  output logic [SDRAM_DATA_WIDTH-1:0] sdram_data,
  output logic                        sdram_we,
  output logic                        sdram_req,
  input  logic                        sdram_ack,
  output logic                        done,
  output logic                        overrun
`ifdef DOWNLOAD_CHECKSUM_EN
  ,
  output logic [15:0]                 checksum
`endif
);

  dl_state_e state, state_next;
  logic download_prev, end_pending;
  logic rise, fall, start, accept, lane3, mismatch, commit;
  logic any_valid, pend_valid, pend_full;
  logic [SDRAM_ADDR_WIDTH-1:0] byte_word_addr, word_addr;
  logic [SDRAM_DATA_WIDTH-1:0] word;

  assign rise           = ioctl_download && !download_prev;
  assign fall           = !ioctl_download && download_prev;
  assign start          = (state == ST_IDLE) && rise;
  assign accept         = (state == ST_FILL) && ioctl_wr;
  assign lane3          = (ioctl_addr[1:0] == 2'd3);
  assign byte_word_addr = word_address(BASE_ADDR, ioctl_addr[IOCTL_ADDR_WIDTH-1:2]);
  assign mismatch       = any_valid && (byte_word_addr != word_addr);
  assign commit         = sdram_req && sdram_ack;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start),
    .wr         (accept),
    .defer      (mismatch),
    .commit     (commit),
    .lane       (ioctl_addr[1:0]),
    .data       (ioctl_data),
    .addr       (byte_word_addr),
    .word       (word),
    .word_addr  (word_addr),
    .any_valid  (any_valid),
    .pend_valid (pend_valid),
    .pend_full  (pend_full)
  );

  // A download that ends mid-request still finishes that request; a byte parked
  // behind it is then flushed on its own before DONE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (rise) state_next = ST_FILL;
      ST_FILL: begin
        if (accept && (mismatch || lane3))
          state_next = ST_REQ;
        else if (fall)
          state_next = (any_valid || accept) ? ST_FLUSH : ST_DONE;
      end
      ST_REQ: begin
        if (commit) begin
          if (end_pending || fall)
            state_next = pend_valid ? ST_FLUSH : ST_DONE;
          else
            state_next = pend_full ? ST_REQ : ST_FILL;
        end
      end
      ST_FLUSH: if (commit) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      download_prev <= 1'b0;
      end_pending   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_next;
      download_prev <= ioctl_download;
      end_pending   <= (state_next == ST_REQ) && (end_pending || fall);
      if (start)
        overrun <= 1'b0;
      else if (ioctl_wr && (state == ST_REQ || state == ST_FLUSH))
        overrun <= 1'b1;
    end
  end

`ifdef DOWNLOAD_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || start)
      checksum <= '0;
    else if (accept)
      checksum <= checksum + {8'h00, ioctl_data};
  end
`endif

  // The host is stalled in the very cycle of a word-completing strobe.
  assign sdram_req  = (state == ST_REQ) || (state == ST_FLUSH);
  assign sdram_we   = sdram_req;
  assign sdram_addr = word_addr;
  assign sdram_data = word;
  assign done       = (state == ST_DONE);
  assign ioctl_wait = sdram_req || (accept && (mismatch || lane3));

endmodule

// File: tb/tb_rom_download_writer.sv
// Self-checking bench for rom_download_writer: two instances (default base and
// a high base) share stimulus; a scoreboard checks every SDRAM write.
module tb_rom_download_writer;

  localparam logic [22:0] HI_BASE = 23'h100000;

  typedef struct {
    logic [22:0] addr;
    logic [31:0] data;
  } write_t;

  typedef struct {
    logic [19:0] addr;
    logic [7:0]  data;
    logic        exp_wait;
    logic        last;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [19:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        sdram_ack = 1'b0;

  logic        ioctl_wait, sdram_we, sdram_req, done, overrun;
  logic [22:0] sdram_addr;
  logic [31:0] sdram_data;
  logic        ioctl_wait_hi, sdram_we_hi, sdram_req_hi, done_hi, overrun_hi;
  logic [22:0] sdram_addr_hi;
  logic [31:0] sdram_data_hi;
`ifdef DOWNLOAD_CHECKSUM_EN
  logic [15:0] checksum, checksum_hi;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int ack_delay = 1;
  bit ack_enable = 1'b1;
  int ack_cnt = 0;
  int done_cnt = 0;

  write_t      exp_q[$];
  write_t      mon_e;
  logic [22:0] mon_hi_addr;
  logic [22:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_valid = '0;
  logic [15:0] m_sum = '0;
  vec_t        vecs[13];

  rom_download_writer dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .done(done), .overrun(overrun)
`ifdef DOWNLOAD_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  rom_download_writer #(.BASE_ADDR(HI_BASE)) dut_hi (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait_hi),
    .sdram_addr(sdram_addr_hi), .sdram_data(sdram_data_hi), .sdram_we(sdram_we_hi),
    .sdram_req(sdram_req_hi), .sdram_ack(sdram_ack), .done(done_hi), .overrun(overrun_hi)
`ifdef DOWNLOAD_CHECKSUM_EN
    , .checksum(checksum_hi)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // SDRAM controller model: acks after ack_delay cycles of req and checks the word.
  always @(negedge clk) begin
    if (reset) begin
      sdram_ack = 1'b0;
      ack_cnt   = 0;
    end else if (sdram_ack) begin
      sdram_ack = 1'b0;
      ack_cnt   = 0;
    end else if (sdram_req && ack_enable) begin
      ack_cnt++;
      if (ack_cnt >= ack_delay) begin
        sdram_ack = 1'b1;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected write: addr %h data %h, expected no write", sdram_addr, sdram_data);
        end else begin
          mon_e       = exp_q.pop_front();
          mon_hi_addr = mon_e.addr + HI_BASE;
          checkOutput("write addr", {9'b0, sdram_addr}, {9'b0, mon_e.addr});
          checkOutput("write data", sdram_data, mon_e.data);
          checkOutput("write addr hi base", {9'b0, sdram_addr_hi}, {9'b0, mon_hi_addr});
          checkOutput("write data hi base", sdram_data_hi, mon_e.data);
          checkOutput("write we", 32'(sdram_we), 32'd1);
        end
      end
    end else begin
      ack_cnt = 0;
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic modelByte(input logic [19:0] a, input logic [7:0] d);
    logic [22:0] wa = {5'b0, a[19:2]};
    int l = int'(a[1:0]);
    if (m_valid != 4'b0 && wa != m_addr) begin
      exp_q.push_back('{m_addr, m_data});
      m_valid = '0;
      m_data  = '0;
    end
    m_data[l*8 +: 8] = d;
    m_valid[l]       = 1'b1;
    m_addr           = wa;
    m_sum            = m_sum + {8'h00, d};
    if (l == 3) begin
      exp_q.push_back('{m_addr, m_data});
      m_valid = '0;
      m_data  = '0;
    end
  endtask

  // Entered and left at negedge+1; behaves like a host honouring ioctl_wait.
  task automatic applyStimulus(input logic [19:0] a, input logic [7:0] d, input logic exp_wait);
    int n = 0;
    while (ioctl_wait === 1'b1 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL host stall: ioctl_wait still 1 after %0d cycles, expected 0", n);
    end
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    #1;
    checkOutput("strobe wait", 32'(ioctl_wait), 32'(exp_wait));
    modelByte(a, d);
    @(negedge clk);
    ioctl_wr = 1'b0;
    #1;
  endtask

  task automatic startDownload();
    m_valid = '0;
    m_data  = '0;
    m_sum   = '0;
    ioctl_download = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic endDownload();
    int start_done = done_cnt;
    int n = 0;
    ioctl_download = 1'b0;
    if (m_valid != 4'b0) begin
      exp_q.push_back('{m_addr, m_data});
      m_valid = '0;
      m_data  = '0;
    end
    while (done_cnt == start_done && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    checkOutput("done pulses", 32'(done_cnt - start_done), 32'd1);
    checkOutput("writes outstanding", 32'(exp_q.size()), 32'd0);
`ifdef DOWNLOAD_CHECKSUM_EN
    checkOutput("checksum", {16'h0, checksum}, {16'h0, m_sum});
`endif
  endtask

  initial begin
    int n;
    int start_done;
    bit in_dl;

    vecs[0]  = '{20'h00000, 8'hAA, 1'b0, 1'b0};
    vecs[1]  = '{20'h00001, 8'hBB, 1'b0, 1'b0};
    vecs[2]  = '{20'h00002, 8'hCC, 1'b0, 1'b0};
    vecs[3]  = '{20'h00003, 8'hDD, 1'b1, 1'b0};
    vecs[4]  = '{20'h00004, 8'hEE, 1'b0, 1'b0};
    vecs[5]  = '{20'h00005, 8'hFF, 1'b0, 1'b1};
    vecs[6]  = '{20'h00008, 8'h12, 1'b0, 1'b0};
    vecs[7]  = '{20'h00009, 8'h34, 1'b0, 1'b0};
    vecs[8]  = '{20'h00014, 8'h56, 1'b1, 1'b0};
    vecs[9]  = '{20'h00017, 8'h78, 1'b1, 1'b0};
    vecs[10] = '{20'h0001E, 8'h9A, 1'b0, 1'b0};
    vecs[11] = '{20'h00007, 8'hC3, 1'b1, 1'b1};
    vecs[12] = '{20'hFFFFF, 8'h5A, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset ioctl_wait", 32'(ioctl_wait), 32'd0);
    checkOutput("reset sdram_req", 32'(sdram_req), 32'd0);
    checkOutput("reset sdram_we", 32'(sdram_we), 32'd0);
    checkOutput("reset sdram_addr", {9'b0, sdram_addr}, 32'd0);
    checkOutput("reset sdram_data", sdram_data, 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    @(negedge clk); #1;

    // Full word with a two-cycle ack: stall lasts strobe cycle plus two REQ cycles.
    ack_delay = 2;
    startDownload();
    applyStimulus(20'h0, 8'h11, 1'b0);
    applyStimulus(20'h1, 8'h22, 1'b0);
    applyStimulus(20'h2, 8'h33, 1'b0);
    applyStimulus(20'h3, 8'h44, 1'b1);
    n = 0;
    while (ioctl_wait && n < 20) begin
      n++;
      @(negedge clk); #1;
    end
    checkOutput("wait cycles", 32'(1 + n), 32'd3);
    endDownload();

    ack_delay = 1;
    in_dl = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (!in_dl) startDownload();
      in_dl = 1'b1;
      applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].exp_wait);
      if (vecs[i].last) begin
        endDownload();
        in_dl = 1'b0;
      end
    end

    // Byte strobed during an unacked request is dropped and flags overrun.
    startDownload();
    ack_enable = 1'b0;
    applyStimulus(20'h40, 8'h01, 1'b0);
    applyStimulus(20'h41, 8'h02, 1'b0);
    applyStimulus(20'h42, 8'h03, 1'b0);
    applyStimulus(20'h43, 8'h04, 1'b1);
    ioctl_addr = 20'h44;
    ioctl_data = 8'h99;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    #1;
    checkOutput("overrun set", 32'(overrun), 32'd1);
    checkOutput("held req", 32'(sdram_req), 32'd1);
    checkOutput("held data", sdram_data, 32'h04030201);
    checkOutput("held addr", {9'b0, sdram_addr}, 32'h10);
    ack_enable = 1'b1;
    applyStimulus(20'h45, 8'h55, 1'b0);
    endDownload();
    checkOutput("overrun sticky", 32'(overrun), 32'd1);

    // A strobe while idle is ignored; the next start clears overrun.
    ioctl_addr = 20'h3;
    ioctl_data = 8'hEE;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    #1;
    checkOutput("idle write no req", 32'(sdram_req), 32'd0);
    startDownload();
    checkOutput("overrun cleared", 32'(overrun), 32'd0);
    applyStimulus(20'h0, 8'hFF, 1'b0);
    applyStimulus(20'h1, 8'hFF, 1'b0);
    applyStimulus(20'h2, 8'h02, 1'b0);
    endDownload();

    // Reset in the middle of a request drops it without a done pulse.
    startDownload();
    ack_enable = 1'b0;
    applyStimulus(20'h100, 8'hA1, 1'b0);
    applyStimulus(20'h101, 8'hA2, 1'b0);
    applyStimulus(20'h102, 8'hA3, 1'b0);
    applyStimulus(20'h103, 8'hA4, 1'b1);
    start_done = done_cnt;
    reset = 1'b1;
    @(negedge clk); #1;
    checkOutput("reset mid req sdram_req", 32'(sdram_req), 32'd0);
    checkOutput("reset mid req wait", 32'(ioctl_wait), 32'd0);
    checkOutput("reset mid req data", sdram_data, 32'd0);
    checkOutput("reset mid req addr", {9'b0, sdram_addr}, 32'd0);
    exp_q.delete();
    ioctl_download = 1'b0;
    reset = 1'b0;
    ack_enable = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("reset mid req no done", 32'(done_cnt - start_done), 32'd0);
    checkOutput("reset mid req stays idle", 32'(sdram_req), 32'd0);

    startDownload();
    applyStimulus(20'h0, 8'h77, 1'b0);
    endDownload();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/rom_download_writer.md
ROM_DOWNLOAD_WRITER -- requirements
Module: rom_download_writer

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 23'h000000, giving the SDRAM word address that maps to download byte 0.
REQ-002 The block SHALL have port clk, input, 1, the system clock (96 MHz).
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port ioctl_download, input, 1, high while a ROM download is in progress.
REQ-005 The block SHALL have port ioctl_wr, input, 1, a one-cycle byte strobe.
REQ-006 The block SHALL have port ioctl_addr, input, 20, the download byte address.
REQ-007 The block SHALL have port ioctl_data, input, 8, the download byte.
REQ-008 The block SHALL have port ioctl_wait, output, 1, asking the host to stall byte writes.
REQ-009 The block SHALL have port sdram_addr, output, 23, the 32-bit word address.
REQ-010 The block SHALL have port sdram_data, output, 32, the packed write word.
REQ-011 The block SHALL have port sdram_we, output, 1, the write enable.
REQ-012 The block SHALL have port sdram_req, output, 1, the request level.
REQ-013 The block SHALL have port sdram_ack, input, 1, a one-cycle acceptance pulse from the controller.
REQ-014 The block SHALL have port done, output, 1, a one-cycle pulse when the download is fully committed to SDRAM.
REQ-015 The block SHALL have port overrun, output, 1, a sticky flag set when a byte is written while the block is busy.

Function
REQ-016 The FSM SHALL have the states IDLE, FILL, REQ, FLUSH and DONE.
REQ-017 IDLE->FILL SHALL occur on a rising edge of ioctl_download, and the word buffer and lane-valid bits SHALL be cleared on that transition.
REQ-018 In FILL, an ioctl_wr SHALL write ioctl_data into lane ioctl_addr[1:0], little-endian (lane 0 = bits 7:0), and set that lane's valid bit.
REQ-019 In FILL, the word address SHALL be latched as BASE_ADDR + ioctl_addr[19:2] on every accepted byte, with modulo-2^23 wrap.
REQ-020 A write to lane 3 SHALL cause FILL->REQ on the next cycle, with ioctl_wait driven high in the same cycle as the lane-3 strobe (combinational).
REQ-021 A write whose word address differs from the latched word while any lane is valid SHALL first commit the old word (FILL->REQ) and then hold the new byte as the first lane of the next word.
REQ-022 In REQ, sdram_req and sdram_we SHALL be high, and sdram_addr/sdram_data SHALL be stable until sdram_ack.
REQ-023 On sdram_ack, sdram_req SHALL drop in the following cycle, the lanes SHALL clear, and the FSM SHALL return to FILL.
REQ-024 ioctl_wait SHALL remain high throughout REQ and FLUSH.
REQ-025 Unwritten lanes SHALL be driven as 8'h00 in sdram_data.
REQ-026 A falling edge of ioctl_download in FILL with any lane valid SHALL cause FILL->FLUSH, issuing one request exactly as in REQ, then FLUSH->DONE on ack.
REQ-027 A falling edge of ioctl_download in FILL with no lane valid SHALL cause FILL->DONE.
REQ-028 A falling edge of ioctl_download during REQ SHALL complete the pending request and then go to DONE.
REQ-029 DONE SHALL pulse done for exactly one cycle and then return to IDLE.
REQ-030 An ioctl_wr in REQ, FLUSH, DONE or IDLE SHALL be ignored, and in REQ/FLUSH it SHALL set overrun, which holds until reset or the next download start.
REQ-031 Minimum latency SHALL be lane-3 strobe to sdram_req high in 1 cycle.

Reset
REQ-032 Reset SHALL force IDLE, drop any pending request without waiting for ack, and clear the buffer.
REQ-033 Reset values SHALL be: ioctl_wait=0, sdram_req=0, sdram_we=0, sdram_addr=0, sdram_data=0, done=0, overrun=0.

Configuration
REQ-034 With DOWNLOAD_CHECKSUM_EN defined, the block SHALL add output checksum[15:0], the modulo-2^16 sum of all accepted bytes, cleared at download start and valid from the done pulse.
REQ-035 Without DOWNLOAD_CHECKSUM_EN, the checksum port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-036 The FSM state enum, SDRAM_ADDR_WIDTH=23, SDRAM_DATA_WIDTH=32 and IOCTL_ADDR_WIDTH=20 SHALL reside in the shared tecmo_pkg.
REQ-037 Lane packing and lane-valid tracking SHALL be placed in one sub-module, byte_packer; the FSM and handshake SHALL stay in rom_download_writer.

Verification
REQ-038 Bytes 11,22,33,44 at addrs 0..3 with ack 2 cycles after req -> one write, addr 0, data 32'h44332211, ioctl_wait high 3 cycles.
REQ-039 Download of 6 bytes AA..FF at addrs 0..5, then download falls -> two writes: 32'hDDCCBBAA at addr 0, 32'h0000FFEE at addr 1, then a single done pulse.
REQ-040 BASE_ADDR=23'h100000 and byte 5A at addr 20'hFFFFF, then end -> write addr 23'h13FFFF, data 32'h5A000000.
REQ-041 Byte strobed while sdram_req is high and unacked -> byte dropped, overrun=1, pending word unchanged.
REQ-042 Reset asserted mid-REQ -> next cycle sdram_req=0, state IDLE, no done pulse.
REQ-043 With DOWNLOAD_CHECKSUM_EN, bytes FF,FF,02 -> checksum 16'h0200 at done.
